mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request sample to mem_ready (legal 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  input  32  byte address of request.
REQ-006 mem_read_valid  input  1  one-cycle read request pulse.
REQ-007 mem_write_valid  input  1  one-cycle write request pulse.
REQ-008 mem_write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 mem_width  input  2  access width: 0=B, 1=H, 2=W, 3=reserved.
REQ-010 mem_ready  output  1  one-cycle response pulse; mem_read_data valid in same cycle.
REQ-011 mem_read_data  output  32  read result, right-justified, zero-extended.
REQ-012 mem_error  output  1  pulses with mem_ready when the completed request was illegal.
REQ-013 overrun  output  1  sticky; set when a request arrives while busy.
REQ-014 load_en / load_addr[31:0] / load_data[31:0]  inputs  backdoor word-write port for program loading.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE, a sampled read_valid or write_valid SHALL capture addr, width, data, op; go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-017 WAIT SHALL count down LATENCY-1 cycles, then enter RESP; mem_ready SHALL rise exactly LATENCY cycles after the request cycle.
REQ-018 RESP SHALL assert mem_ready for one cycle and return to IDLE; mem_ready SHALL never be high two consecutive cycles.
REQ-019 A new request in the RESP cycle SHALL be accepted (back-to-back); requests in WAIT SHALL be dropped and set overrun.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher bits ignored (aliasing).
REQ-021 Byte write SHALL update lane addr[1:0] with data[7:0]; half write SHALL update lanes addr[1]*2..+1 with data[15:0]; word write all lanes.
REQ-022 Reads SHALL return selected byte/half shifted to bit 0, upper bits zero.
REQ-023 Write commit SHALL occur on the clock edge that raises mem_ready; read data SHALL reflect array contents before that commit.
REQ-024 Illegal = width 3, half with addr[0]=1, word with addr[1:0]!=0, or read_valid and write_valid both high; SHALL complete normally with mem_error=1, no array write, read_data=0.
REQ-025 Backdoor load_en SHALL write load_data to word load_addr[..:2] in one cycle; if it collides with a core write commit to the same word, the core write wins.

Reset
REQ-026 rst SHALL force IDLE, mem_ready=0, mem_error=0, mem_read_data=0, overrun=0, discarding any pending request, effective next cycle.
REQ-027 rst SHALL NOT clear the memory array; a pending write aborted by rst SHALL NOT commit.
REQ-028 Requests sampled in the same cycle as rst SHALL be ignored.

Structure
REQ-029 Width codes MEM_B/MEM_H/MEM_W and the 2-bit width type SHALL live in shared package mem_pkg, also used by core.
REQ-030 Lane alignment (byte-enable generation, store shift, load extract, misalignment check) SHALL be one combinational sub-module mem_lane_align.
REQ-031 Array SHALL be a single inferred 32-bit-wide RAM with per-byte enables.

Verification
REQ-032 LATENCY=1: write W 0xDEADBEEF @0x10, then read W @0x10 -> mem_ready 1 cycle after each request; read_data=0xDEADBEEF, mem_error=0.
REQ-033 Write B 0xAB @0x11, read W @0x10 -> 0xDEADABEF; read B @0x11 -> 0x000000AB; read H @0x12 -> 0x0000DEAD.
REQ-034 LATENCY=3: read @0x0 with second request 1 cycle later -> single mem_ready at +3, overrun=1; back-to-back request in RESP cycle accepted, ready at +3 again.
REQ-035 Write H @0x13 data 0x1234 -> mem_ready with mem_error=1; read W @0x10 unchanged.
REQ-036 LATENCY=4: issue write W 0x55AA55AA @0x20, assert rst 2 cycles later -> no mem_ready; read @0x20 returns prior value.
REQ-037 load_en words 0x00000013 @0x0 and 0x00100093 @0x4, then reads @0x0, @0x4 -> returns loaded words.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-width codes and responder state encoding
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B   = 2'd0,
        MEM_H   = 2'd1,
        MEM_W   = 2'd2,
        MEM_RSV = 2'd3
    } mem_width_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable, store replication, load extract and misalignment check
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  mem_width_t  i_width,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_lanes,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    // Store data is replicated across lanes so the byte enables alone select the target lane.
    always_comb begin
        o_byte_en     = 4'b0000;
        o_store_lanes = i_store_data;
        o_load_data   = 32'd0;
        o_misaligned  = 1'b0;
        case (i_width)
            MEM_B: begin
                o_byte_en     = 4'b0001 << i_addr_lo;
                o_store_lanes = {4{i_store_data[7:0]}};
                o_load_data   = {24'd0, 8'(i_load_word >> {i_addr_lo, 3'b000})};
            end
            MEM_H: begin
                o_misaligned  = i_addr_lo[0];
                o_byte_en     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_store_lanes = {2{i_store_data[15:0]}};
                o_load_data   = {16'd0, i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0]};
            end
            MEM_W: begin
                o_misaligned  = |i_addr_lo;
                o_byte_en     = 4'b1111;
                o_store_lanes = i_store_data;
                o_load_data   = i_load_word;
            end
            default: begin
                o_misaligned  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder with backdoor load port
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_read_valid,
    input  logic        mem_write_valid,
    input  logic [31:0] mem_write_data,
    input  logic [1:0]  mem_width,
    output logic        mem_ready,
    output logic [31:0] mem_read_data,
    output logic        mem_error,
    output logic        overrun,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    mem_state_t    r_state, w_state_nx;
    logic [3:0]    r_cnt, w_cnt_nx;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lo;
    mem_width_t    r_width;
    logic [31:0]   r_wdata;
    logic          r_write, r_err, r_overrun;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_req, w_both, w_in_wait, w_accept, w_enter_resp, w_commit;
    logic [AW-1:0] w_sel_idx, w_ram_idx;
    logic [1:0]    w_sel_lo;
    mem_width_t    w_sel_width;
    logic [31:0]   w_sel_wdata, w_ram_wdata, w_st_lanes, w_ld_data, w_rd_word;
    logic          w_sel_write, w_sel_err, w_st_misaligned;
    logic [3:0]    w_st_be, w_ram_we;
    logic [31:0]   w_unused_st_load, w_unused_ld_lanes;
    logic [3:0]    w_unused_ld_be;
    logic          w_unused_ld_mis, w_unused_addr;

    assign w_req     = mem_read_valid | mem_write_valid;
    assign w_both    = mem_read_valid & mem_write_valid;
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_accept  = w_req && !w_in_wait;

    // The commit edge sees the live request when LATENCY is 1, otherwise the captured one.
    assign w_sel_idx   = w_in_wait ? r_idx   : mem_addr[AW+1:2];
    assign w_sel_lo    = w_in_wait ? r_lo    : mem_addr[1:0];
    assign w_sel_width = w_in_wait ? r_width : mem_width_t'(mem_width);
    assign w_sel_wdata = w_in_wait ? r_wdata : mem_write_data;
    assign w_sel_write = w_in_wait ? r_write : mem_write_valid;
    assign w_sel_err   = w_in_wait ? r_err   : (w_both || w_st_misaligned);

    assign w_enter_resp = (w_in_wait && r_cnt == 4'd0) || (w_accept && LATENCY == 1);
    assign w_commit     = !rst && w_enter_resp && w_sel_write && !w_sel_err;

    mem_lane_align u_st_align (
        .i_addr_lo    (w_sel_lo),
        .i_width      (w_sel_width),
        .i_store_data (w_sel_wdata),
        .i_load_word  (32'd0),
        .o_byte_en    (w_st_be),
        .o_store_lanes(w_st_lanes),
        .o_load_data  (w_unused_st_load),
        .o_misaligned (w_st_misaligned)
    );

    assign w_rd_word = r_mem[r_idx];

    mem_lane_align u_ld_align (
        .i_addr_lo    (r_lo),
        .i_width      (r_width),
        .i_store_data (r_wdata),
        .i_load_word  (w_rd_word),
        .o_byte_en    (w_unused_ld_be),
        .o_store_lanes(w_unused_ld_lanes),
        .o_load_data  (w_ld_data),
        .o_misaligned (w_unused_ld_mis)
    );

    // One write port: a core commit takes the port outright, so it wins any same-word backdoor load.
    assign w_ram_we    = w_commit ? w_st_be    : (load_en ? 4'hF : 4'h0);
    assign w_ram_idx   = w_commit ? w_sel_idx  : load_addr[AW+1:2];
    assign w_ram_wdata = w_commit ? w_st_lanes : load_data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we[i]) r_mem[w_ram_idx][8*i +: 8] <= w_ram_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_idx   <= mem_addr[AW+1:2];
                r_lo    <= mem_addr[1:0];
                r_width <= mem_width_t'(mem_width);
                r_wdata <= mem_write_data;
                r_write <= mem_write_valid;
                r_err   <= w_both || w_st_misaligned;
            end
            if (w_req && w_in_wait) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                if (r_cnt == 4'd0) w_state_nx = ST_RESP;
                else               w_cnt_nx   = r_cnt - 4'd1;
            end
            default: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nx = ST_RESP;
                    end else begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = CNT_INIT;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
        endcase
    end

    assign mem_ready     = (r_state == ST_RESP);
    assign mem_error     = mem_ready && r_err;
    assign mem_read_data = (mem_ready && !r_err && !r_write) ? w_ld_data : 32'd0;
    assign overrun       = r_overrun;

    assign w_unused_addr = ^{mem_addr[31:AW+2], load_addr[31:AW+2], load_addr[1:0]};

endmodule
